fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequencer for the dual-issue instruction fetch path: owns the fetch PC, drives the
//  synchronous instruction BRAM (64-bit bundle, 1-cycle read latency) and presents one
//  bundle per cycle to decode. Handles boot, stall/interlock hold, branch redirect
//  (incl. odd-slot targets) and halt. Counts stall and redirect events.
//  Sits between the BRAM and decode; redirect comes from the branch unit.
// PARAMETERS
//  PC_W      32            fetch PC / byte-address width
//  RESET_PC  32'h0         first bundle address after reset
//  CNT_W     32            width of saturating event counters
// PORTS
//  clk             in   1      clock
//  rst             in   1      async reset, active-high
//  interlock       in   1      decode hazard; hold current bundle
//  fetch_stall     in   1      pipeline stall; hold current bundle
//  redirect_valid  in   1      branch/jump taken this cycle
//  redirect_pc     in   PC_W   target byte address, 4-byte aligned
//  halt_req        in   1      stop fetching after current bundle is accepted
//  mem_addr        out  PC_W   BRAM read byte address, bits[2:0] always 0
//  mem_dout        in   64     BRAM data for address presented previous cycle
//  inst_out        out  64     bundle to decode; [63:32]=slot0 (older), [31:0]=slot1
//  pc_out          out  PC_W   byte address of bundle on inst_out (8-aligned)
//  inst_valid      out  1      inst_out holds real instructions
//  stall_cnt       out  CNT_W  cycles with advance=0 in RUN (saturating)
//  redirect_cnt    out  CNT_W  accepted redirects (saturating)
// BEHAVIOUR
//  - Clock clk; reset rst is asynchronous, active-high. Single clock domain.
//  - NOP word = {3'b111,29'b0}; bubble bundle = {NOP,NOP}.
//  - advance = ~fetch_stall & ~interlock. Registers: state, f_pc, odd_mask, counters.
//  - States: BOOT, RUN, HALT. Reset -> BOOT, f_pc=RESET_PC, odd_mask=0, counters=0.
//  - Outputs under reset: mem_addr=RESET_PC, inst_out=bubble, inst_valid=0, pc_out=RESET_PC.
//  - BOOT (one cycle): mem_addr=RESET_PC, inst_valid=0 -> RUN. Redirect in BOOT is honoured.
//  - RUN: inst_out=mem_dout with slot0 replaced by NOP if odd_mask; inst_valid=1; pc_out=f_pc.
//    mem_addr combinational: redirect ? {redirect_pc[PC_W-1:3],3'b0}
//                          : advance ? f_pc+8 : f_pc (re-read keeps mem_dout stable on hold).
//    f_pc <= mem_addr each cycle; odd_mask <= redirect_valid & redirect_pc[2], else 0 on advance,
//    unchanged on hold.
//  - Redirect has priority over stall, interlock and halt_req; bundle on inst_out that cycle is
//    squashed (discarded by consumer); target bundle appears next cycle, zero bubble cycles.
//  - Redirect while stalled: target bundle presented and held until advance.
//  - halt_req in RUN with advance and no redirect -> HALT; halt_req without advance: stay RUN.
//  - HALT: inst_valid=0, inst_out=bubble, mem_addr=f_pc; exit only on redirect -> RUN.
//  - Latency: mem_addr change to inst_out update = 1 cycle.
//  - f_pc+8 wraps modulo 2^PC_W (0xFFFF_FFF8 -> 0x0).
//  - stall_cnt increments when state==RUN & ~advance & ~redirect_valid; redirect_cnt on every
//    redirect_valid in BOOT/RUN/HALT; both hold at all-ones.
//  - rst asserted mid-operation: immediate return to reset values regardless of state.
// STRUCTURE
//  - fetch_pkg: NOP_INST, BUBBLE_BUNDLE, FETCH_STEP=8, typedef enum {BOOT,RUN,HALT} fetch_state_t.
//  - One sub-module: sat_counter #(CNT_W) (inc, clear-on-rst), instantiated twice.
//  - BRAM instance lives outside; fetch_ctrl only drives address and consumes data.
// TESTING
//  - Reset release, no stall: inst_valid=0 for 1 cycle, then pc_out 0x0,0x8,0x10... each cycle;
//    mem_addr leads pc_out by one cycle.
//  - fetch_stall high 3 cycles at pc_out=0x10: pc_out/inst_out hold, mem_addr=0x10,
//    stall_cnt=3; next bundle 0x18 one cycle after release.
//  - redirect_pc=0x104 with interlock high: next cycle pc_out=0x100, inst_out[63:32]=NOP,
//    held until interlock drops, then 0x108 with no mask; redirect_cnt=1.
//  - halt_req with advance at pc_out=0x40: next cycle inst_valid=0, bubble; redirect 0x200
//    -> pc_out=0x200, inst_valid=1 following cycle.
//  - Wrap: redirect to 0xFFFF_FFF8, advance -> pc_out 0xFFFF_FFF8 then 0x0.
//  - rst pulse mid-stall in RUN: outputs to reset values asynchronously; BOOT then pc_out=0x0;
//    counters preset near all-ones saturate and do not wrap.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and state type for the dual-issue fetch sequencer.
// A bubble bundle is two NOP words; fetch advances one 8-byte bundle per step.
package fetch_pkg;

  localparam logic [31:0] NOP_INST      = {3'b111, 29'b0};
  localparam logic [63:0] BUBBLE_BUNDLE = {NOP_INST, NOP_INST};
  localparam int unsigned FETCH_STEP    = 8;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Cleared by the asynchronous active-high reset.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, addresses the 1-cycle BRAM and hands one
// 64-bit bundle per cycle to decode, handling hold, redirect, halt and boot.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int             PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int             CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             interlock,
  input  logic             fetch_stall,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             halt_req,
  output logic [PC_W-1:0]  mem_addr,
  input  logic [63:0]      mem_dout,
  output logic [63:0]      inst_out,
  output logic [PC_W-1:0]  pc_out,
  output logic             inst_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_f_pc;
  logic            r_odd_mask;

  logic            w_advance;
  logic            w_running;
  logic [PC_W-1:0] w_redirect_addr;
  logic [PC_W-1:0] w_next_seq;
  logic [PC_W-1:0] w_mem_addr;
  logic            w_stall_inc;
  logic            w_unused;

  assign w_advance       = ~fetch_stall & ~interlock;
  assign w_running       = (r_state == RUN);
  assign w_redirect_addr = {redirect_pc[PC_W-1:3], 3'b000};
  assign w_next_seq      = r_f_pc + PC_W'(FETCH_STEP);
  assign w_unused        = ^redirect_pc[1:0];

  // Holding re-reads f_pc so the BRAM keeps returning the same bundle.
  always_comb begin
    w_mem_addr = r_f_pc;
    if (redirect_valid) begin
      w_mem_addr = w_redirect_addr;
    end else if (w_running && w_advance) begin
      w_mem_addr = w_next_seq;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= BOOT;
      r_f_pc     <= RESET_PC;
      r_odd_mask <= 1'b0;
    end else begin
      r_f_pc <= w_mem_addr;
      if (redirect_valid) begin
        r_odd_mask <= redirect_pc[2];
      end else if (w_advance) begin
        r_odd_mask <= 1'b0;
      end
      case (r_state)
        BOOT:    r_state <= RUN;
        RUN:     if (!redirect_valid && w_advance && halt_req) r_state <= HALT;
        HALT:    if (redirect_valid) r_state <= RUN;
        default: r_state <= BOOT;
      endcase
    end
  end

  // An odd-slot redirect target squashes the older slot of its bundle.
  assign mem_addr   = w_mem_addr;
  assign pc_out     = r_f_pc;
  assign inst_valid = w_running;
  assign inst_out   = !w_running ? BUBBLE_BUNDLE :
                      r_odd_mask ? {NOP_INST, mem_dout[31:0]} : mem_dout;

  assign w_stall_inc = w_running & ~w_advance & ~redirect_valid;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect_valid),
    .count (redirect_cnt)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a bundle-level reference model queues the
// expected observation per cycle; a negedge monitor pops and compares.
module tb_fetch_ctrl;

  localparam int          CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP     = 32'hE000_0000;
  localparam logic [63:0] BUBBLE  = {NOP, NOP};

  logic        clk = 1'b0;
  logic        rst;
  logic        interlock, fetch_stall, redirect_valid, halt_req;
  logic [31:0] redirect_pc, mem_addr, pc_out;
  logic [63:0] mem_dout, inst_out;
  logic        inst_valid;
  logic [CNT_W-1:0] stall_cnt, redirect_cnt;

  always #5 clk = ~clk;

  fetch_ctrl #(.PC_W(32), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .interlock      (interlock),
    .fetch_stall    (fetch_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .mem_addr       (mem_addr),
    .mem_dout       (mem_dout),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .inst_valid     (inst_valid),
    .stall_cnt      (stall_cnt),
    .redirect_cnt   (redirect_cnt)
  );

  // Instruction memory contents: a fixed function of the bundle address.
  function automatic logic [63:0] bram(input logic [31:0] a);
    return {a ^ 32'h5A5A_0F0F, ~a + 32'h1357_9BDF};
  endfunction

  always @(posedge clk) mem_dout <= bram(mem_addr);

  typedef struct {
    logic             valid;
    logic             halted;
    logic [31:0]      pc;
    logic [31:0]      addr;
    logic [63:0]      inst;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] rc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  // Reference model: what bundle is shown, whether fetch is booting/halted.
  bit          m_boot, m_halt, m_mask;
  logic [31:0] m_pc;
  int          m_sc, m_rc;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got empty queue expected an entry (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("inst_valid", inst_valid, e.valid);
        check("mem_addr", mem_addr, e.addr);
        check("stall_cnt", stall_cnt, e.sc);
        check("redirect_cnt", redirect_cnt, e.rc);
        if (e.valid) begin
          check("pc_out", pc_out, e.pc);
          check("inst_out", inst_out, e.inst);
        end else if (e.halted) begin
          check("halt_bubble", inst_out, BUBBLE);
        end
      end
    end
  end

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : CNT_MAX;
  endfunction

  task automatic model_reset();
    m_boot = 1'b1; m_halt = 1'b0; m_mask = 1'b0; m_pc = 32'h0;
    m_sc = 0; m_rc = 0;
    sb.delete();
  endtask

  // Apply inputs for the current cycle and queue what the DUT must show now.
  task automatic issue(input bit st, input bit il, input bit rv, input logic [31:0] rpc, input bit hr);
    exp_t        e;
    logic [31:0] nxt;
    bit          nmask, adv;
    fetch_stall = st; interlock = il; redirect_valid = rv; redirect_pc = rpc; halt_req = hr;
    adv = !st && !il;
    e.valid  = !m_boot && !m_halt;
    e.halted = m_halt;
    e.pc     = m_pc;
    e.inst   = m_mask ? {NOP, bram(m_pc)[31:0]} : bram(m_pc);
    e.sc     = CNT_W'(m_sc);
    e.rc     = CNT_W'(m_rc);
    nxt = m_pc; nmask = m_mask;
    if (rv) begin
      nxt = rpc & 32'hFFFF_FFF8; nmask = rpc[2];
      m_boot = 1'b0; m_halt = 1'b0;
      m_rc = sat_inc(m_rc);
    end else if (m_boot) begin
      nmask = 1'b0; m_boot = 1'b0;
    end else if (!m_halt) begin
      if (adv) begin
        nxt = m_pc + 32'd8; nmask = 1'b0;
        if (hr) m_halt = 1'b1;
      end else begin
        m_sc = sat_inc(m_sc);
      end
    end
    e.addr = nxt;
    m_pc = nxt; m_mask = nmask;
    sb.push_back(e);
  endtask

  task automatic step(input bit st, input bit il, input bit rv, input logic [31:0] rpc, input bit hr);
    @(posedge clk); #1;
    issue(st, il, rv, rpc, hr);
    chk_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst_out", inst_out, BUBBLE);
    check("rst_stall_cnt", stall_cnt, '0);
    check("rst_redirect_cnt", redirect_cnt, '0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    issue(0, 0, 0, 32'h0, 0);
    chk_en = 1'b1;
  endtask

  // Asynchronous pulse between clock edges, stall left as it was.
  task automatic pulse_reset();
    @(posedge clk); #3;
    chk_en = 1'b0;
    redirect_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    release_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; interlock = 0; fetch_stall = 0; redirect_valid = 0;
    redirect_pc = 32'h0; halt_req = 0;
    model_reset();
    #2;
    check_reset_outputs();
    release_reset();

    // Sequential fetch, then a 3-cycle stall on the 0x10 bundle.
    idle(2);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0, 0);
    idle(3);

    // Odd-slot redirect under interlock, held, then released.
    step(0, 1, 1, 32'h0000_0104, 0);
    step(0, 1, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0);
    idle(3);

    // Halt after accepting a bundle, stay halted, redirect restarts.
    step(0, 0, 1, 32'h0000_0040, 0);
    step(0, 0, 0, 32'h0, 1);
    idle(2);
    step(1, 0, 0, 32'h0, 1);
    step(0, 0, 1, 32'h0000_0200, 0);
    idle(2);
    step(1, 0, 0, 32'h0, 1);
    idle(1);

    // PC wrap past the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFF8, 0);
    idle(3);
    step(0, 0, 1, 32'hFFFF_FFFC, 0);
    idle(2);

    // Drive both counters into saturation, then reset while stalled.
    for (int i = 0; i < CNT_MAX + 4; i++) step(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < CNT_MAX + 2; i++) step(i[0], 0, 1, 32'h100 + 32'(i) * 4, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h0, 0);
    pulse_reset();
    idle(4);

    // Redirect in the boot cycle.
    step(1, 0, 0, 32'h0, 0);
    pulse_reset();
    sb.delete();
    m_boot = 1'b1;
    chk_en = 1'b0;
    @(posedge clk); #1;
    model_reset();
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    issue(0, 0, 1, 32'h0000_0A04, 0);
    chk_en = 1'b1;
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit          st, il, rv, hr;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 99) < 20);
      il  = ($urandom_range(0, 99) < 15);
      rv  = ($urandom_range(0, 99) < 8);
      hr  = ($urandom_range(0, 99) < 5);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1C))
                                         : ($urandom & 32'hFFFF_FFFC);
      step(st, il, rv, rpc, hr);
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
